exec_core: RTL and testbench

EXEC_CORE -- requirements
Module: exec_core

---
 rtl/exec_core_if.sv | 33 +++
 rtl/exec_core.sv | 187 ++++++++++++++++++
 tb/tb_exec_core.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_core_if.sv
// Program-load, start and status bundle between a host and exec_core.
// Latency: none, wires only.
// Backpressure: none; the core ignores load/start strobes while busy.
interface exec_core_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 8
);
    logic                  load_en;
    logic [AW-1:0]         load_addr;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  start;
    logic [AW-1:0]         start_addr;
    logic [AW-1:0]         ipointer;
    logic [7:0]            opcode;
    logic [DATA_WIDTH-1:0] r0;
    logic [DATA_WIDTH-1:0] r1;
    logic [DATA_WIDTH-1:0] debug;
    logic                  busy;
    logic                  halted;
    logic                  err;
    logic                  zero;
    logic                  carry;

    modport master (
        output load_en, load_addr, load_data, start, start_addr,
        input  ipointer, opcode, r0, r1, debug, busy, halted, err, zero, carry
    );

    modport slave (
        input  load_en, load_addr, load_data, start, start_addr,
        output ipointer, opcode, r0, r1, debug, busy, halted, err, zero, carry
    );
endinterface

// File: rtl/exec_core.sv
// Tiny multi-cycle CPU: 3-word instructions fetched from a local RAM, 16 regs.
// Latency: 5 cycles per instruction (F0,F1,F2,RD,EX); status mirrors lag one cycle.
// Backpressure: load/start accepted only in IDLE or HALT, silently dropped while busy.
module exec_core #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 16,
    parameter int RAM_DEPTH  = 256,
    parameter int DEBUG_ADDR = 18
) (
    input  logic          clk,
    input  logic          reset,
    exec_core_if.slave    bus
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam logic [AW-1:0] DBG_A = AW'(DEBUG_ADDR);

    localparam logic [7:0] OP_MOVI  = 8'd1;
    localparam logic [7:0] OP_LOAD  = 8'd2;
    localparam logic [7:0] OP_STORE = 8'd3;
    localparam logic [7:0] OP_ADD   = 8'd4;
    localparam logic [7:0] OP_SUB   = 8'd5;
    localparam logic [7:0] OP_JMP   = 8'd6;
    localparam logic [7:0] OP_JZ    = 8'd7;
    localparam logic [7:0] OP_HALT  = 8'd8;

    typedef enum logic [2:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_RD, S_EX, S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] ram  [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [AW-1:0]         ip;
    logic [7:0]            op;
    logic [RW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] opnd;
    logic [DATA_WIDTH-1:0] mem_val;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] rs_val;
    logic                  err_q, zero_q, carry_q;
    logic [DATA_WIDTH-1:0] r0_q, r1_q, debug_q;

    logic                  idle_like, busy, halted;
    logic                  start_ok, load_ok;
    logic                  ex, ex_store, ex_wr_reg, ex_flags, ex_bad;

    logic [AW-1:0]         opnd_addr;
    logic [RW-1:0]         rs_idx;
    logic [DATA_WIDTH:0]   sum, diff;
    logic [DATA_WIDTH-1:0] wr_val;
    logic [AW-1:0]         ip_seq, ip_nxt;

    logic                  ram_we;
    logic [AW-1:0]         ram_wa;
    logic [DATA_WIDTH-1:0] ram_wd;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_HALT: if (bus.start) state_nxt = S_F0;
            S_F0:           state_nxt = S_F1;
            S_F1:           state_nxt = S_F2;
            S_F2:           state_nxt = S_RD;
            S_RD:           state_nxt = S_EX;
            S_EX:           state_nxt = (op >= OP_HALT) ? S_HALT : S_F0;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        idle_like = (state == S_IDLE) || (state == S_HALT);
        busy      = !idle_like;
        halted    = (state == S_HALT);
        start_ok  = idle_like && bus.start;
        // Gating with reset keeps a load from landing while the core is held in reset.
        load_ok   = idle_like && bus.load_en && reset;
        ex        = (state == S_EX);
        ex_store  = ex && (op == OP_STORE);
        ex_wr_reg = ex && ((op == OP_MOVI) || (op == OP_LOAD) ||
                           (op == OP_ADD)  || (op == OP_SUB));
        ex_flags  = ex && ((op == OP_ADD) || (op == OP_SUB));
        ex_bad    = ex && (op > OP_HALT);
    end

    assign opnd_addr = opnd[AW-1:0];
    assign rs_idx    = opnd[RW-1:0];
    assign sum       = {1'b0, rd_val} + {1'b0, rs_val};
    assign diff      = {1'b0, rd_val} - {1'b0, rs_val};
    assign ip_seq    = ip + AW'(3);

    always_comb begin
        wr_val = opnd;
        unique case (op)
            OP_LOAD: wr_val = mem_val;
            OP_ADD:  wr_val = sum[DATA_WIDTH-1:0];
            OP_SUB:  wr_val = diff[DATA_WIDTH-1:0];
            default: wr_val = opnd;
        endcase
    end

    // HALT and illegal opcodes park the pointer on the offending instruction.
    always_comb begin
        ip_nxt = ip_seq;
        if (op >= OP_HALT)                    ip_nxt = ip;
        else if (op == OP_JMP)                ip_nxt = opnd_addr;
        else if (op == OP_JZ && rd_val == '0) ip_nxt = opnd_addr;
    end

    always_comb begin
        ram_we = ex_store || load_ok;
        ram_wa = ex_store ? opnd_addr : bus.load_addr;
        ram_wd = ex_store ? rd_val    : bus.load_data;
    end

    // RAM is deliberately outside the reset domain so programs survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_wa] <= ram_wd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ip      <= '0;
            op      <= '0;
            rd_idx  <= '0;
            opnd    <= '0;
            mem_val <= '0;
            rd_val  <= '0;
            rs_val  <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            r0_q    <= '0;
            r1_q    <= '0;
            debug_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            r0_q    <= regs[0];
            r1_q    <= regs[1];
            debug_q <= ram[DBG_A];

            if (start_ok) begin
                ip    <= bus.start_addr;
                err_q <= 1'b0;
            end else if (ex) begin
                ip    <= ip_nxt;
            end

            if (state == S_F0) op     <= ram[ip][7:0];
            if (state == S_F1) rd_idx <= ram[ip + AW'(1)][RW-1:0];
            if (state == S_F2) opnd   <= ram[ip + AW'(2)];
            if (state == S_RD) begin
                mem_val <= ram[opnd_addr];
                rd_val  <= regs[rd_idx];
                rs_val  <= regs[rs_idx];
            end

            if (ex_wr_reg) regs[rd_idx] <= wr_val;
            if (ex_flags) begin
                zero_q  <= (wr_val == '0);
                carry_q <= (op == OP_ADD) ? sum[DATA_WIDTH] : diff[DATA_WIDTH];
            end
            if (ex_bad) err_q <= 1'b1;
        end
    end

    assign bus.ipointer = ip;
    assign bus.opcode   = op;
    assign bus.r0       = r0_q;
    assign bus.r1       = r1_q;
    assign bus.debug    = debug_q;
    assign bus.busy     = busy;
    assign bus.halted   = halted;
    assign bus.err      = err_q;
    assign bus.zero     = zero_q;
    assign bus.carry    = carry_q;
endmodule

// File: tb/tb_exec_core.sv
// Bench for exec_core: ALU vector table plus hand-built programs, scoreboarded.
module tb_exec_core;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    exec_core_if #(.DATA_WIDTH(16), .AW(8)) bus ();

    exec_core #(.DATA_WIDTH(16), .NUM_REGS(16), .RAM_DEPTH(256), .DEBUG_ADDR(18)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [15:0] NOP = 16'd0, MOVI = 16'd1, LOAD = 16'd2, STORE = 16'd3,
                            ADD = 16'd4, SUB = 16'd5, JMP = 16'd6, JZ = 16'd7, HALT = 16'd8;

    typedef struct {
        logic [15:0] op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          c;
        int          z;
    } alu_vec_t;

    // Any field set to -1 is not compared.
    typedef struct {
        string name;
        int    cycles;
        int    r0;
        int    r1;
        int    dbg;
        int    ip;
        int    err;
        int    z;
        int    c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string n, input int act, input int exp);
        if (exp >= 0) begin
            total++;
            if (act != exp) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", n, act, exp);
            end
        end
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        @(posedge clk); #1;
        bus.load_en   = 1'b0;
    endtask

    task automatic instr(input logic [7:0] a, input logic [15:0] op,
                         input logic [15:0] rd, input logic [15:0] opnd);
        logic [7:0] a1, a2;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        load_word(a, op);
        load_word(a1, rd);
        load_word(a2, opnd);
    endtask

    task automatic run(input exp_t e, input logic [7:0] sa, input bit inject);
        int   cyc;
        int   lim;
        exp_t got;
        sb.push_back(e);
        lim = (e.cycles > 0) ? e.cycles + 20 : 400;
        bus.start      = 1'b1;
        bus.start_addr = sa;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({e.name, "/err_clr"}, int'(bus.err), 0);
        chk({e.name, "/busy"}, int'(bus.busy), 1);
        cyc = 0;
        while (!bus.halted && cyc < lim) begin
            @(posedge clk); #1;
            cyc++;
            bus.load_en   = inject && (cyc == 2);
            bus.load_addr = 8'd18;
            bus.load_data = 16'hBEEF;
        end
        bus.load_en = 1'b0;
        if (!bus.halted) begin
            total++;
            bad++;
            $display("FAIL %s/timeout: got running after %0d cycles want halted", e.name, cyc);
        end
        repeat (2) @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.name, "/cycles"}, cyc, got.cycles);
        chk({got.name, "/r0"}, int'(bus.r0), got.r0);
        chk({got.name, "/r1"}, int'(bus.r1), got.r1);
        chk({got.name, "/debug"}, int'(bus.debug), got.dbg);
        chk({got.name, "/ip"}, int'(bus.ipointer), got.ip);
        chk({got.name, "/err"}, int'(bus.err), got.err);
        chk({got.name, "/zero"}, int'(bus.zero), got.z);
        chk({got.name, "/carry"}, int'(bus.carry), got.c);
        chk({got.name, "/busy_end"}, int'(bus.busy), 0);
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, "/ip"}, int'(bus.ipointer), 0);
        chk({n, "/opcode"}, int'(bus.opcode), 0);
        chk({n, "/r0"}, int'(bus.r0), 0);
        chk({n, "/r1"}, int'(bus.r1), 0);
        chk({n, "/debug"}, int'(bus.debug), 0);
        chk({n, "/busy"}, int'(bus.busy), 0);
        chk({n, "/halted"}, int'(bus.halted), 0);
        chk({n, "/err"}, int'(bus.err), 0);
        chk({n, "/zero"}, int'(bus.zero), 0);
        chk({n, "/carry"}, int'(bus.carry), 0);
    endtask

    alu_vec_t tbl[7];

    initial begin
        tbl[0] = '{ADD, 16'hFFFF, 16'h0001, 16'h0000, 1, 1};
        tbl[1] = '{SUB, 16'h0000, 16'h0001, 16'hFFFF, 1, 0};
        tbl[2] = '{ADD, 16'h0003, 16'h0004, 16'h0007, 0, 0};
        tbl[3] = '{SUB, 16'h0005, 16'h0005, 16'h0000, 0, 1};
        tbl[4] = '{ADD, 16'h8000, 16'h8000, 16'h0000, 1, 1};
        tbl[5] = '{SUB, 16'h1234, 16'h0234, 16'h1000, 0, 0};
        tbl[6] = '{SUB, 16'h0002, 16'h0003, 16'hFFFF, 1, 0};

        bus.load_en    = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        bus.start_addr = '0;

        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Two-number sum stored to the debug word.
        load_word(8'd16, 16'd5);
        load_word(8'd17, 16'd7);
        load_word(8'd18, 16'd0);
        instr(8'd0, LOAD, 16'd0, 16'd16);
        instr(8'd3, LOAD, 16'd1, 16'd17);
        instr(8'd6, ADD, 16'd0, 16'd1);
        instr(8'd9, STORE, 16'd0, 16'd18);
        instr(8'd12, HALT, 16'd0, 16'd0);
        run('{"sum", 25, 12, 7, 12, 12, 0, 0, 0}, 8'd0, 1'b0);

        // ALU table: MOVI r0,a; MOVI r1,b; op r0,r1; HALT
        for (int i = 0; i < 7; i++) begin
            instr(8'd100, MOVI, 16'd0, tbl[i].a);
            instr(8'd103, MOVI, 16'd1, tbl[i].b);
            instr(8'd106, tbl[i].op, 16'd0, 16'd1);
            instr(8'd109, HALT, 16'd0, 16'd0);
            run('{$sformatf("alu%0d", i), 20, int'(tbl[i].res), int'(tbl[i].b), -1, 109,
                  0, tbl[i].z, tbl[i].c}, 8'd100, 1'b0);
        end

        // Countdown loop: JZ must fall through twice and be taken on the third pass.
        load_word(8'd18, 16'h0055);
        instr(8'd40, MOVI, 16'd4, 16'd3);
        instr(8'd43, MOVI, 16'd5, 16'd1);
        instr(8'd46, SUB, 16'd4, 16'd5);
        instr(8'd49, JZ, 16'd4, 16'd55);
        instr(8'd52, JMP, 16'd0, 16'd46);
        instr(8'd55, STORE, 16'd4, 16'd18);
        instr(8'd58, HALT, 16'd0, 16'd0);
        run('{"loop", 60, 16'hFFFF, 3, 0, 58, 0, 1, 0}, 8'd40, 1'b0);

        // Illegal opcode halts with err; a second start clears err before re-faulting.
        load_word(8'd0, 16'h00FF);
        run('{"illegal", 5, 16'hFFFF, 3, 0, 0, 1, 1, 0}, 8'd0, 1'b0);
        chk("illegal/opcode", int'(bus.opcode), 8'hFF);
        chk("illegal/halted", int'(bus.halted), 1);
        run('{"illegal2", 5, 16'hFFFF, 3, 0, 0, 1, 1, 0}, 8'd0, 1'b0);

        // Instruction wrapping the top of RAM; a load pulse while busy must be dropped.
        load_word(8'd255, MOVI);
        load_word(8'd0, 16'd0);
        load_word(8'd1, 16'h00A5);
        load_word(8'd2, HALT);
        run('{"wrap", 10, 16'h00A5, 3, 0, 2, 0, 1, 0}, 8'd255, 1'b1);

        // Reset asserted during RD of a STORE aborts the write.
        load_word(8'd18, 16'h1234);
        instr(8'd60, STORE, 16'd0, 16'd18);
        instr(8'd63, HALT, 16'd0, 16'd0);
        bus.start      = 1'b1;
        bus.start_addr = 8'd60;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid/opcode_pre", int'(bus.opcode), STORE);
        reset = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid/debug_kept", int'(bus.debug), 16'h1234);
        chk("rst_mid/idle_busy", int'(bus.busy), 0);
        chk("rst_mid/idle_halted", int'(bus.halted), 0);
        chk("rst_mid/regs_cleared", int'(bus.r0), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid/no_autostart", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
